// File: rtl/serial_sub8_if.sv
// serial_sub8_if: start/busy/done handshake and operand/result bus for serial_sub8
// Signals:
//   start, a, b, bin       requester -> subtractor
//   d, bout, ovf, zero     subtractor -> requester (result)
//   busy, done             subtractor -> requester (status)
// Modports: master (requester side), slave (subtractor side)
interface serial_sub8_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;
  logic         zero;
  logic         busy;
  logic         done;
  modport master (output start, a, b, bin, input d, bout, ovf, zero, busy, done);
  modport slave  (input start, a, b, bin, output d, bout, ovf, zero, busy, done);
endinterface

// File: rtl/serial_sub8.sv
// serial_sub8: bit-serial W-bit subtractor d = a - b - bin, LSB first, one bit per clock
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   s    serial_sub8_if.slave: start/a/b/bin in; d/bout/ovf/zero/busy/done out
module serial_sub8 #(parameter int W = 8) (
  input logic clk,
  input logic rst,
  serial_sub8_if.slave s
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        st;
  logic [W-1:0]  ra, rb, dr;
  logic [CW-1:0] cnt;
  logic          br, bout_r, ovf_r, zero_r, busy_r, done_r;
  logic          ai, bi, di, bn, last;
  logic [W-1:0]  dn;
  // dn is d with the bit being processed this cycle already in place, so the
  // completion flags see the final difference rather than the stale register
  always_comb begin
    ai   = ra[cnt];
    bi   = rb[cnt];
    di   = ai ^ bi ^ br;
    bn   = (~ai & bi) | (~(ai ^ bi) & br);
    last = cnt == CW'(W - 1);
    dn   = dr;
    dn[cnt] = di;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st     <= IDLE;
      ra     <= '0;
      rb     <= '0;
      dr     <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (st == RUN) begin
      dr  <= dn;
      br  <= bn;
      cnt <= cnt + 1'b1;
      if (last) begin
        st     <= DONE;
        bout_r <= bn;
        ovf_r  <= (ra[W-1] != rb[W-1]) & (di != ra[W-1]);
        zero_r <= dn == '0;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end else if (s.start) begin
      st     <= RUN;
      ra     <= s.a;
      rb     <= s.b;
      br     <= s.bin;
      cnt    <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end
  assign s.d    = dr;
  assign s.bout = bout_r;
  assign s.ovf  = ovf_r;
  assign s.zero = zero_r;
  assign s.busy = busy_r;
  assign s.done = done_r;
endmodule

// File: tb/tb_serial_sub8.sv
// tb_serial_sub8: directed self-checking bench for serial_sub8
module tb_serial_sub8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  serial_sub8_if #(.W(8)) s();
  serial_sub8 #(.W(8)) dut (.clk(clk), .rst(rst), .s(s.slave));
  always #5 clk = ~clk;

  // drive a start pulse; returns 1 time unit after the accepting edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge clk);
    s.a = a; s.b = b; s.bin = bin; s.start = 1'b1;
    @(posedge clk);
    #1 s.start = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    s.start = 1'b0; s.a = '0; s.b = '0; s.bin = 1'b0;
    rst = 1'b1;
    wait_edges(2);
    checks++; if ({s.d, s.bout, s.ovf, s.zero, s.busy, s.done} !== 13'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {s.d, s.bout, s.ovf, s.zero, s.busy, s.done}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_basic;
    start_op(8'd5, 8'd3, 1'b0);
    checks++; if ({s.busy, s.done} !== 2'b10) begin failures++; $display("FAIL basic_busy_after_accept got=%b exp=10", {s.busy, s.done}); end
    s.a = 8'hff; s.b = 8'hff; s.bin = 1'b1;
    wait_edges(7);
    checks++; if ({s.busy, s.done} !== 2'b10) begin failures++; $display("FAIL basic_busy_edge7 got=%b exp=10", {s.busy, s.done}); end
    wait_edges(1);
    checks++; if ({s.busy, s.done} !== 2'b01) begin failures++; $display("FAIL basic_done_edge8 got=%b exp=01", {s.busy, s.done}); end
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd2, 3'b000}) begin failures++; $display("FAIL basic_5m3 got d=%0d f=%b exp d=2 f=000", s.d, {s.bout, s.ovf, s.zero}); end
    wait_edges(3);
    checks++; if ({s.d, s.done} !== {8'd2, 1'b1}) begin failures++; $display("FAIL basic_hold got d=%0d done=%b exp d=2 done=1", s.d, s.done); end
    start_op(8'd3, 8'd5, 1'b0);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd254, 3'b100}) begin failures++; $display("FAIL basic_3m5 got d=%0d f=%b exp d=254 f=100", s.d, {s.bout, s.ovf, s.zero}); end
  endtask

  task automatic test_overflow;
    start_op(8'd100, 8'd200, 1'b1);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd155, 3'b110}) begin failures++; $display("FAIL ovf_100m200m1 got d=%0d f=%b exp d=155 f=110", s.d, {s.bout, s.ovf, s.zero}); end
    start_op(8'd128, 8'd1, 1'b0);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd127, 3'b010}) begin failures++; $display("FAIL ovf_128m1 got d=%0d f=%b exp d=127 f=010", s.d, {s.bout, s.ovf, s.zero}); end
  endtask

  task automatic test_zero;
    start_op(8'd0, 8'd0, 1'b1);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd255, 3'b100}) begin failures++; $display("FAIL zero_0m0m1 got d=%0d f=%b exp d=255 f=100", s.d, {s.bout, s.ovf, s.zero}); end
    start_op(8'd7, 8'd7, 1'b0);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero} !== {8'd0, 3'b001}) begin failures++; $display("FAIL zero_7m7 got d=%0d f=%b exp d=0 f=001", s.d, {s.bout, s.ovf, s.zero}); end
  endtask

  task automatic test_back_to_back;
    start_op(8'd9, 8'd4, 1'b0);
    wait_edges(2);
    @(negedge clk);
    s.a = 8'd50; s.b = 8'd1; s.start = 1'b1;
    @(posedge clk);
    #1 s.start = 1'b0;
    checks++; if ({s.busy, s.done} !== 2'b10) begin failures++; $display("FAIL b2b_start_in_run got=%b exp=10", {s.busy, s.done}); end
    wait_edges(5);
    checks++; if ({s.d, s.bout, s.ovf, s.zero, s.done} !== {8'd5, 4'b0001}) begin failures++; $display("FAIL b2b_ignored_start got d=%0d f=%b exp d=5 f=0001", s.d, {s.bout, s.ovf, s.zero, s.done}); end
    start_op(8'd0, 8'd1, 1'b0);
    checks++; if ({s.busy, s.done, s.bout, s.zero} !== 4'b1000) begin failures++; $display("FAIL b2b_accept_in_done got=%b exp=1000", {s.busy, s.done, s.bout, s.zero}); end
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero, s.done} !== {8'd255, 4'b1001}) begin failures++; $display("FAIL b2b_second_op got d=%0d f=%b exp d=255 f=1001", s.d, {s.bout, s.ovf, s.zero, s.done}); end
  endtask

  task automatic test_async_reset;
    start_op(8'd200, 8'd100, 1'b0);
    wait_edges(4);
    #2 rst = 1'b1;
    #1;
    checks++; if ({s.d, s.bout, s.ovf, s.zero, s.busy, s.done} !== 13'd0) begin failures++; $display("FAIL async_reset_drop got=%h exp=0", {s.d, s.bout, s.ovf, s.zero, s.busy, s.done}); end
    @(negedge clk) rst = 1'b0;
    wait_edges(12);
    checks++; if ({s.d, s.busy, s.done} !== 10'd0) begin failures++; $display("FAIL async_reset_idle got=%h exp=0", {s.d, s.busy, s.done}); end
    start_op(8'd200, 8'd100, 1'b0);
    wait_edges(8);
    checks++; if ({s.d, s.bout, s.ovf, s.zero, s.done} !== {8'd100, 4'b0101}) begin failures++; $display("FAIL async_reset_fresh got d=%0d f=%b exp d=100 f=0101", s.d, {s.bout, s.ovf, s.zero, s.done}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_zero;
    test_back_to_back;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
